// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler
//   Car-level SCAN scheduler for a single elevator. Floor call pulses are
//   latched into a pending bitmap; the car keeps travelling in its committed
//   direction while calls remain ahead of it, reverses when only calls behind
//   remain, and parks in IDLE when nothing is pending.
//
//   Optional build macro: EMERG_FLUSH_EN
//     defined   : entering EMERGENCY drops all pending calls, calls are
//                 ignored while stopped, and the car restarts from IDLE
//                 with the door closed.
//     undefined : pending calls survive and keep latching during EMERGENCY;
//                 the car resumes exactly where it was frozen.
//
//   Handshake note: there is no valid/ready pair here. floor_req is a
//   fire-and-forget pulse bitmap sampled every rising edge, and
//   emergency_stopped is a level that takes effect on the following edge.
module floor_request_scheduler #(
  parameter int NUM_FLOORS    = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_FLOORS-1:0]                 floor_req,
  input  logic                                  emergency_stopped,
  output logic [$clog2(NUM_FLOORS)-1:0]         current_floor,
  output logic                                  dir_up,
  output logic                                  dir_down,
  output logic                                  moving,
  output logic                                  door_open,
  output logic                                  arrived,
  output logic [NUM_FLOORS-1:0]                 pending
);

  localparam int FLOOR_W = $clog2(NUM_FLOORS);
  localparam int TW      = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW      = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR_OPEN = 3'd3,
    EMERGENCY = 3'd4
  } state_t;

  state_t            state;
  state_t            saved_state;
  logic [TW-1:0]     travel_cnt;
  logic [DW-1:0]     door_cnt;
  logic              last_dir_up;

  // Combinational helpers used by the state machine
  logic [NUM_FLOORS-1:0] pend_eff;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic [NUM_FLOORS-1:0] nf_mask;
  logic [NUM_FLOORS-1:0] pend_door;
  logic [FLOOR_W-1:0]    nf;
  logic                  going_up;
  logic                  at_limit;
  logic                  above_cur;
  logic                  below_cur;
  logic                  door_above;
  logic                  door_below;
  logic                  ahead_nf;
  logic                  behind_nf;

  // Bits strictly above floor f
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  // Bits strictly below floor f
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  // Decode the call picture around the car: current floor and next floor
  always_comb begin
    pend_eff   = pending | floor_req;
    cur_mask   = NUM_FLOORS'(1) << current_floor;
    going_up   = (state == MOVE_UP);
    at_limit   = going_up ? (current_floor == TOP_FLOOR) : (current_floor == '0);
    nf         = going_up ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);
    nf_mask    = NUM_FLOORS'(1) << nf;
    above_cur  = |(pend_eff & above_mask(current_floor));
    below_cur  = |(pend_eff & below_mask(current_floor));
    // While the door is open, a call for this floor is absorbed by the door
    pend_door  = pend_eff & ~cur_mask;
    door_above = |(pend_door & above_mask(current_floor));
    door_below = |(pend_door & below_mask(current_floor));
    ahead_nf   = going_up ? |(pend_eff & above_mask(nf)) : |(pend_eff & below_mask(nf));
    behind_nf  = going_up ? |(pend_eff & below_mask(nf)) : |(pend_eff & above_mask(nf));
  end

  // Motion outputs are a pure decode of the registered state
  assign dir_up   = (state == MOVE_UP);
  assign dir_down = (state == MOVE_DOWN);
  assign moving   = (state == MOVE_UP) || (state == MOVE_DOWN);

  // Main scheduler FSM: state, position, calls, timers and door/arrival flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      saved_state   <= IDLE;
      current_floor <= '0;
      pending       <= '0;
      travel_cnt    <= '0;
      door_cnt      <= '0;
      last_dir_up   <= 1'b1;
      door_open     <= 1'b0;
      arrived       <= 1'b0;
    end else begin
      arrived <= 1'b0;
      if (state == EMERGENCY) begin
        // Frozen: timers hold, door holds, car does not move
`ifdef EMERG_FLUSH_EN
        if (!emergency_stopped) begin
          state     <= IDLE;
          door_open <= 1'b0;
        end
`else
        pending <= pend_eff;
        if (!emergency_stopped) begin
          state     <= saved_state;
          door_open <= (saved_state == DOOR_OPEN);
        end
`endif
      end else if (emergency_stopped) begin
        saved_state <= state;
        state       <= EMERGENCY;
`ifdef EMERG_FLUSH_EN
        pending     <= '0;
`else
        pending     <= pend_eff;
`endif
      end else begin
        case (state)
          IDLE: begin
            if ((pend_eff & cur_mask) != '0) begin
              state     <= DOOR_OPEN;
              door_open <= 1'b1;
              door_cnt  <= '0;
              pending   <= pend_eff & ~cur_mask;
            end else begin
              pending <= pend_eff;
              if (above_cur && below_cur) begin
                state       <= last_dir_up ? MOVE_UP : MOVE_DOWN;
                travel_cnt  <= '0;
              end else if (above_cur) begin
                state       <= MOVE_UP;
                last_dir_up <= 1'b1;
                travel_cnt  <= '0;
              end else if (below_cur) begin
                state       <= MOVE_DOWN;
                last_dir_up <= 1'b0;
                travel_cnt  <= '0;
              end
            end
          end

          MOVE_UP, MOVE_DOWN: begin
            if (at_limit) begin
              // Cannot travel past the shaft ends; park instead
              state   <= IDLE;
              pending <= pend_eff;
            end else if (travel_cnt == TRAVEL_LAST) begin
              current_floor <= nf;
              arrived       <= 1'b1;
              travel_cnt    <= '0;
              if ((pend_eff & nf_mask) != '0) begin
                state     <= DOOR_OPEN;
                door_open <= 1'b1;
                door_cnt  <= '0;
                pending   <= pend_eff & ~nf_mask;
              end else begin
                pending <= pend_eff;
                if (ahead_nf) begin
                  state <= state;
                end else if (behind_nf) begin
                  state       <= going_up ? MOVE_DOWN : MOVE_UP;
                  last_dir_up <= ~going_up;
                end else begin
                  state <= IDLE;
                end
              end
            end else begin
              travel_cnt <= travel_cnt + TW'(1);
              pending    <= pend_eff;
            end
          end

          DOOR_OPEN: begin
            pending <= pend_door;
            if ((floor_req & cur_mask) != '0) begin
              door_cnt <= '0;
            end else if (door_cnt == DOOR_LAST) begin
              door_open  <= 1'b0;
              travel_cnt <= '0;
              if (last_dir_up ? door_above : door_below) begin
                state <= last_dir_up ? MOVE_UP : MOVE_DOWN;
              end else if (last_dir_up ? door_below : door_above) begin
                state       <= last_dir_up ? MOVE_DOWN : MOVE_UP;
                last_dir_up <= ~last_dir_up;
              end else begin
                state <= IDLE;
              end
            end else begin
              door_cnt <= door_cnt + DW'(1);
            end
          end

          default: begin
            state     <= IDLE;
            door_open <= 1'b0;
            pending   <= pend_eff;
          end
        endcase
      end
    end
  end

endmodule
